weight_buffer_loader: RTL

- Writer-side counterpart of the per-layer parameter source blocks.
- Accepts one full parameter tile as a valid/ready stream of DEPTH beats, each DATA_SIZE lanes of DATA_WIDTH bits, and stores it in an internal register array.
- Then replays the stored tile REPEAT times to the downstream compute block over a valid/ready stream, and returns to loading.
- Sits between the off-chip/DMA parameter stream and a linear/conv layer's weight or bias input.

---
 rtl/weight_buffer_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/weight_buffer_loader.sv
// weight_buffer_loader
// Captures one parameter tile (DEPTH beats of DATA_SIZE lanes) from an
// input valid/ready stream, then replays the stored tile REPEAT times on an
// output valid/ready stream before accepting the next tile.
module weight_buffer_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_SIZE  = 32,
  parameter int DEPTH      = 8,
  parameter int REPEAT     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [DATA_SIZE],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [DATA_SIZE],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  load_done
);

  localparam int PTR_W  = $clog2(DEPTH) + 1;
  localparam int REP_W  = $clog2(REPEAT) + 1;
  // Memory address width; a one-entry array still needs a one-bit index.
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] LAST_BEAT = PTR_W'(DEPTH - 1);
  localparam logic [REP_W-1:0] LAST_REP  = REP_W'(REPEAT - 1);

  localparam logic [0:0] ST_LOAD   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]            r_state;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [REP_W-1:0]      r_rep_cnt;
  logic                  r_load_done;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH][DATA_SIZE];

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [ADDR_W-1:0]     w_wr_addr;
  logic [ADDR_W-1:0]     w_rd_addr;

  // Handshake qualifiers: both sides are masked while reset is asserted.
  assign data_in_ready  = (r_state == ST_LOAD) && !rst;
  assign data_out_valid = (r_state == ST_STREAM) && !rst;
  assign load_done      = r_load_done;

  assign w_in_fire  = data_in_valid && data_in_ready;
  assign w_out_fire = data_out_valid && data_out_ready;

  // Pointers never exceed DEPTH-1, so the low bits address the array directly.
  assign w_wr_addr = r_wr_ptr[ADDR_W-1:0];
  assign w_rd_addr = r_rd_ptr[ADDR_W-1:0];

  // Combinational replay read, forced to zero whenever no beat is offered.
  always_comb begin
    for (int i = 0; i < DATA_SIZE; i++) begin
      if (data_out_valid) begin
        data_out[i] = r_mem[w_rd_addr][i];
      end else begin
        data_out[i] = '0;
      end
    end
  end

  // Tile storage: written only on accepted input beats, deliberately unreset.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_mem[w_wr_addr] <= data_in;
    end
  end

  // Load/replay sequencer with write pointer, read pointer and replay count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rep_cnt   <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            if (r_wr_ptr == LAST_BEAT) begin
              r_wr_ptr    <= '0;
              r_state     <= ST_STREAM;
              r_load_done <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
          end
        end
        ST_STREAM: begin
          if (w_out_fire) begin
            if (r_rd_ptr == LAST_BEAT) begin
              r_rd_ptr <= '0;
              if (r_rep_cnt == LAST_REP) begin
                r_rep_cnt <= '0;
                r_state   <= ST_LOAD;
              end else begin
                r_rep_cnt <= r_rep_cnt + REP_W'(1);
              end
            end else begin
              r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
          end
        end
        default: begin
          r_state   <= ST_LOAD;
          r_wr_ptr  <= '0;
          r_rd_ptr  <= '0;
          r_rep_cnt <= '0;
        end
      endcase
    end
  end

endmodule
